image_feeder: RTL and testbench

IMAGE_FEEDER -- requirements
Module: image_feeder

---
 rtl/image_feeder_pkg.sv | 21 ++
 rtl/feeder_fifo.sv | 57 +++++
 rtl/image_feeder.sv | 183 ++++++++++++++++++
 tb/tb_image_feeder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_feeder_pkg.sv
// image_feeder_pkg: feeder entries of the shared config address map, FSM encoding
// and the window-length helper used by image_feeder.
package image_feeder_pkg;

    localparam int unsigned CFG_FEEDER_BASE  = 32'd8;
    localparam int unsigned CFG_FEEDER_SIZE  = 32'd9;
    localparam int unsigned CFG_FEEDER_START = 32'd10;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_FETCH = 4'b0010,
        S_FLUSH = 4'b0100,
        S_DONE  = 4'b1000
    } feeder_state_e;

    // A zero window length still delivers one word per window.
    function automatic logic [15:0] eff_win_len(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// feeder_fifo: 2-entry FIFO whose head entry drives the outputs straight from flops.
// Pushing into a full FIFO is prevented upstream by the read-issue throttle.
module feeder_fifo #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             head_vld_q;
    logic             tail_vld_q;
    logic             pop;

    assign pop = rd_en && head_vld_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else if (pop) begin
            if (tail_vld_q) begin
                head_q     <= tail_q;
                tail_vld_q <= wr_en;
                if (wr_en) begin
                    tail_q <= wr_data;
                end
            end else begin
                head_vld_q <= wr_en;
                if (wr_en) begin
                    head_q <= wr_data;
                end
            end
        end else if (wr_en) begin
            if (!head_vld_q) begin
                head_q     <= wr_data;
                head_vld_q <= 1'b1;
            end else begin
                tail_q     <= wr_data;
                tail_vld_q <= 1'b1;
            end
        end
    end

    assign rd_data  = head_q;
    assign rd_valid = head_vld_q;
    assign count    = {1'b0, head_vld_q} + {1'b0, tail_vld_q};

endmodule

// File: rtl/image_feeder.sv
// image_feeder: reads (win_nb+1) windows of win_len words from the image buffer and
// streams them to the layers. Define IMAGE_FEEDER_STALL_CNT_EN to add stall_cnt.
module image_feeder
    import image_feeder_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int BUF_AWIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    output logic [BUF_AWIDTH-1:0]         buf_addr,
    output logic                          buf_rd_en,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] buf_data,
    output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    output logic                          image_last,
    output logic                          image_val,
    input  logic                          image_rdy,
    output logic                          busy,
    output logic                          done
`ifdef IMAGE_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt
`endif
);
    localparam int DW = GROUP_NB * IMG_WIDTH;

    logic [BUF_AWIDTH-1:0] base_q;
    logic [15:0]           win_len_q;
    logic [7:0]            win_nb_q;
    logic                  cfg_base_hit;
    logic                  cfg_size_hit;
    logic                  start_req;
    logic                  start_acc;
    logic                  unused_cfg_hi;

    feeder_state_e         state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [BUF_AWIDTH-1:0] addr_q;
    logic [15:0]           word_q;
    logic [15:0]           len_q;
    logic [7:0]            win_q;
    logic [7:0]            nb_q;
    logic                  pend_q;
    logic                  pend_last_q;

    logic [1:0]            fifo_cnt;
    logic [DW:0]           fifo_rd_data;
    logic                  fifo_pop;
    logic [1:0]            fill_d;
    logic                  rd_issue;
    logic                  rd_last;
    logic                  rd_final;

    assign cfg_base_hit  = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_FEEDER_BASE));
    assign cfg_size_hit  = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_FEEDER_SIZE));
    assign start_req     = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_FEEDER_START)) && cfg_data[0];
    assign start_acc     = start_req && (state_q == S_IDLE);
    assign unused_cfg_hi = ^cfg_data[CFG_DWIDTH-1:24];

    // Config registers deliberately survive reset.
    always_ff @(posedge clk) begin
        if (cfg_base_hit) begin
            base_q <= cfg_data[BUF_AWIDTH-1:0];
        end
        if (cfg_size_hit) begin
            win_len_q <= cfg_data[15:0];
            win_nb_q  <= cfg_data[23:16];
        end
    end

    // fill_d: FIFO occupancy after this edge, counting the word already in flight.
    assign fifo_pop = image_val && image_rdy;
    assign fill_d   = fifo_cnt + {1'b0, pend_q} - {1'b0, fifo_pop};
    assign rd_issue = (state_q == S_FETCH) && (fill_d < 2'd2);
    assign rd_last  = (word_q == len_q - 16'd1);
    assign rd_final = rd_issue && rd_last && (win_q == nb_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            word_q      <= '0;
            win_q       <= '0;
            len_q       <= 16'd1;
            nb_q        <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            pend_q      <= rd_issue;
            pend_last_q <= rd_last;
            if (rd_issue) begin
                addr_q <= addr_q + 1'b1;
                if (rd_last) begin
                    word_q <= '0;
                    win_q  <= win_q + 8'd1;
                end else begin
                    word_q <= word_q + 16'd1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_acc) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        addr_q  <= base_q;
                        word_q  <= '0;
                        win_q   <= '0;
                        len_q   <= eff_win_len(win_len_q);
                        nb_q    <= win_nb_q;
                    end
                end
                S_FETCH: begin
                    if (rd_final) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (fill_d == 2'd0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    feeder_fifo #(
        .WIDTH(DW + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pend_q),
        .wr_data ({buf_data, pend_last_q}),
        .rd_en   (image_rdy),
        .rd_data (fifo_rd_data),
        .rd_valid(image_val),
        .count   (fifo_cnt)
    );

    assign image_bus  = fifo_rd_data[DW:1];
    assign image_last = fifo_rd_data[0];
    assign buf_addr   = addr_q;
    assign buf_rd_en  = rd_issue;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef IMAGE_FEEDER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (image_val && !image_rdy && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_image_feeder.sv
// tb_image_feeder: directed transfers checked against a queue model of the expected word stream.
module tb_image_feeder;
    import image_feeder_pkg::*;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cfg_data = '0;
    logic [4:0]  cfg_addr = '0;
    logic        cfg_valid = 1'b0;
    logic [9:0]  buf_addr;
    logic        buf_rd_en;
    logic [63:0] buf_data = '0;
    logic [63:0] image_bus;
    logic        image_last;
    logic        image_val;
    logic        image_rdy = 1'b1;
    logic        busy;
    logic        done;
`ifdef IMAGE_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    int    start_cyc = 0;
    int    last_acc_cyc = -100;
    int    acc_cnt = 0;
    bit    expect_first = 1'b0;
    bit    done_seen = 1'b0;
    word_t exp_q[$];
    word_t acc_q[$];
    logic [9:0] m_base = '0;
    int    m_len = 1;
    int    m_nb = 0;

    image_feeder #(
        .CFG_DWIDTH(32),
        .CFG_AWIDTH(5),
        .GROUP_NB  (4),
        .IMG_WIDTH (16),
        .BUF_AWIDTH(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_addr  (cfg_addr),
        .cfg_valid (cfg_valid),
        .buf_addr  (buf_addr),
        .buf_rd_en (buf_rd_en),
        .buf_data  (buf_data),
        .image_bus (image_bus),
        .image_last(image_last),
        .image_val (image_val),
        .image_rdy (image_rdy),
        .busy      (busy),
        .done      (done)
`ifdef IMAGE_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer contents: every pixel lane carries its address plus a lane tag.
    function automatic logic [63:0] word_at(input logic [9:0] a);
        logic [15:0] p;
        p = {6'd0, a};
        return {p + 16'h3000, p + 16'h2000, p + 16'h1000, p};
    endfunction

    initial forever begin
        @(posedge clk);
        if (buf_rd_en) buf_data <= word_at(buf_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       image_rdy = 1'b1;
            1:       image_rdy = ~image_rdy;
            default: image_rdy = 1'b0;
        endcase
    endtask

    task automatic cfg_wr(input int unsigned a, input logic [31:0] d);
        cfg_addr  = 5'(a);
        cfg_data  = d;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic setup(input logic [9:0] base, input int len, input int nb);
        m_base = base;
        m_len  = len;
        m_nb   = nb;
        cfg_wr(CFG_FEEDER_BASE, {22'd0, base});
        cfg_wr(CFG_FEEDER_SIZE, {8'd0, 8'(nb), 16'(len)});
    endtask

    // Expected stream: contiguous wrapping addresses, last on every win_len-th word.
    task automatic kick();
        int eff;
        eff = (m_len == 0) ? 1 : m_len;
        exp_q.delete();
        acc_q.delete();
        acc_cnt   = 0;
        done_seen = 1'b0;
        for (int w = 0; w < (m_nb + 1) * eff; w++) begin
            exp_q.push_back({word_at(10'((int'(m_base) + w) % 1024)), (w % eff) == eff - 1});
        end
        start_cyc    = cyc;
        expect_first = 1'b1;
        cfg_wr(CFG_FEEDER_START, 32'd1);
    endtask

    task automatic wait_done(input bit disturb);
        int i;
        i = 0;
        while (!done_seen && i < 300) begin
            step();
            i++;
            if (disturb && i == 5) begin
                cfg_wr(CFG_FEEDER_BASE, 32'h0000_0200);
                cfg_wr(CFG_FEEDER_SIZE, 32'h0000_0002);
                cfg_wr(CFG_FEEDER_START, 32'd1);
            end
        end
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout actual=no_done required=done_within_300_cycles");
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) step();
    endtask

    task automatic monitor();
        word_t       e;
        logic        prev_stall;
        logic [63:0] prev_bus;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_bus   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_stall) begin
                    check("hold_val", 64'(image_val), 64'd1);
                    check("hold_bus", image_bus, prev_bus);
                    check("hold_last", 64'(image_last), 64'(prev_last));
                end
                if (expect_first && image_val) begin
                    check("first_latency", 64'(cyc - start_cyc), 64'd3);
                    check("busy_in_xfer", 64'(busy), 64'd1);
                    expect_first = 1'b0;
                end
                if (image_val && image_rdy) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_word actual=%h required=no_word", image_bus);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", image_bus, e.d);
                        check("word_last", 64'(image_last), 64'(e.l));
                        acc_q.push_back({image_bus, image_last});
                        acc_cnt++;
                        if (exp_q.size() == 0) last_acc_cyc = cyc;
                    end
                end
                if (done) begin
                    check("done_timing", 64'(cyc - last_acc_cyc), 64'd1);
                    check("busy_at_done", 64'(busy), 64'd0);
                    done_seen = 1'b1;
                end
            end
            prev_stall = rst && image_val && !image_rdy;
            prev_bus   = image_bus;
            prev_last  = image_last;
        end
    endtask

    initial begin
        logic [8:0] mask;
        int         i;
        fork
            monitor();
        join_none

        rst = 1'b0;
        repeat (3) step();
        check("rst_image_val", 64'(image_val), 64'd0);
        check("rst_image_last", 64'(image_last), 64'd0);
        check("rst_buf_rd_en", 64'(buf_rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_buf_addr", 64'(buf_addr), 64'd0);
        check("rst_image_bus", image_bus, 64'd0);
        rst = 1'b1;
        step();

        // Single window from 0x010.
        rdy_mode = 0;
        setup(10'h010, 4, 0);
        kick();
        wait_done(1'b0);
        check("t1_count", 64'(acc_q.size()), 64'd4);
        check("t1_first_word", acc_q[0].d, 64'h3010_2010_1010_0010);
        check("t1_last_word", acc_q[3].d, 64'h3013_2013_1013_0013);
        check("t1_last_flags", {60'd0, acc_q[3].l, acc_q[2].l, acc_q[1].l, acc_q[0].l}, 64'h8);

        // Three windows of three words.
        setup(10'h020, 3, 2);
        kick();
        wait_done(1'b0);
        mask = '0;
        for (int k = 0; k < 9; k++) mask[k] = acc_q[k].l;
        check("t2_count", 64'(acc_q.size()), 64'd9);
        check("t2_last_mask", 64'(mask), 64'h124);

        // Ready toggling, with config and start written mid-transfer.
        rdy_mode = 1;
        setup(10'h100, 8, 0);
        kick();
        wait_done(1'b1);
        check("t3_count", 64'(acc_q.size()), 64'd8);
        check("t3_word7", 64'(acc_q[7].d[15:0]), 64'h0107);
        rdy_mode = 0;

        // Address wrap at the top of the buffer.
        setup(10'h3FE, 4, 0);
        kick();
        wait_done(1'b0);
        check("t4_addr0", 64'(acc_q[0].d[15:0]), 64'h03FE);
        check("t4_addr1", 64'(acc_q[1].d[15:0]), 64'h03FF);
        check("t4_addr2", 64'(acc_q[2].d[15:0]), 64'h0000);
        check("t4_addr3", 64'(acc_q[3].d[15:0]), 64'h0001);

        // Zero window length behaves as one.
        setup(10'h050, 0, 1);
        kick();
        wait_done(1'b0);
        check("t5_count", 64'(acc_q.size()), 64'd2);
        check("t5_lasts", {62'd0, acc_q[1].l, acc_q[0].l}, 64'd3);

        // Reset after two accepted words, then replay.
        setup(10'h080, 8, 0);
        kick();
        i = 0;
        while (acc_cnt < 2 && i < 50) begin
            step();
            i++;
        end
        check("t6_accepted_before_rst", 64'(acc_cnt), 64'd2);
        rst       = 1'b0;
        image_rdy = 1'b0;
        step();
        check("t6_val_after_rst", 64'(image_val), 64'd0);
        check("t6_busy_after_rst", 64'(busy), 64'd0);
        check("t6_rd_en_after_rst", 64'(buf_rd_en), 64'd0);
        rst          = 1'b1;
        expect_first = 1'b0;
        exp_q.delete();
        step();
        kick();
        wait_done(1'b0);
        check("t6_replay_count", 64'(acc_q.size()), 64'd8);
        check("t6_replay_first", acc_q[0].d, 64'h3080_2080_1080_0080);

`ifdef IMAGE_FEEDER_STALL_CNT_EN
        rdy_mode = 2;
        setup(10'h040, 4, 0);
        kick();
        i = 0;
        while (!image_val && i < 20) begin
            step();
            i++;
        end
        repeat (5) step();
        check("stall_cnt", 64'(stall_cnt), 64'd5);
        rdy_mode  = 0;
        image_rdy = 1'b1;
        wait_done(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
